// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM state codes and instruction field positions
// shared by the writeback select sequencer.
package cpu_pkg;
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam int OP_MSB = 7;
    localparam int OP_LSB = 5;
    localparam int RD_MSB = 4;
    localparam int RD_LSB = 3;
endpackage

// File: rtl/wb_select_ctrl.sv
// wb_select_ctrl: one-at-a-time sequencer driving the result-mux select,
// register-file write strobe/address and PC-advance pulse.
module wb_select_ctrl
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 8,
    parameter int MUL_LAT = 3,
    parameter int REG_AW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [2:0]         code_sel,
    output logic               reg_we,
    output logic [REG_AW-1:0]  reg_waddr,
    output logic               pc_inc,
    output logic               busy,
    output logic               halted
);
    logic [2:0]             state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [RD_MSB-RD_LSB:0] rd_q, rd_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   unused_bits;

    assign unused_bits = ^instr_in[RD_LSB-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (instr_valid) begin
                op_d    = instr_in[OP_MSB:OP_LSB];
                rd_d    = instr_in[RD_MSB:RD_LSB];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = op_q == OP_HALT ? S_HALT : op_q == OP_NOP ? S_IDLE : S_EXEC;
                cnt_d   = op_q == OP_MUL ? 4'(MUL_LAT - 1) : 4'd0;
            end
            S_EXEC: begin
                cnt_d   = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
                state_d = cnt_q != 4'd0 ? S_EXEC : S_WB;
            end
            S_WB:    state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come from registers only, so async reset clears them at once.
    assign instr_ready = state_q == S_IDLE;
    assign code_sel    = (state_q == S_EXEC || state_q == S_WB) ? op_q : 3'b000;
    assign reg_we      = state_q == S_WB;
    assign reg_waddr   = REG_AW'(rd_q);
    assign pc_inc      = state_q == S_WB || (state_q == S_DECODE && op_q == OP_NOP);
    assign busy        = state_q != S_IDLE && state_q != S_HALT;
    assign halted      = state_q == S_HALT;
endmodule

// File: tb/tb_wb_select_ctrl.sv
// tb_wb_select_ctrl: scoreboard bench; each accepted instruction queues its
// expected retirement, which the negedge monitor pops on pc_inc/reg_we.
module tb_wb_select_ctrl;
    localparam int MUL_LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instr_in;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] code_sel;
    logic       reg_we;
    logic [1:0] reg_waddr;
    logic       pc_inc;
    logic       busy;
    logic       halted;

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        int         stamp;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    wb_select_ctrl #(.INSTR_W(8), .MUL_LAT(MUL_LAT), .REG_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .code_sel(code_sel), .reg_we(reg_we),
        .reg_waddr(reg_waddr), .pc_inc(pc_inc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (pc_inc || reg_we)) begin
            if (sb.size() == 0) chk("unexpected_retire", {30'd0, reg_we, pc_inc}, 32'd0);
            else begin
                e = sb.pop_front();
                chk("ret_we", reg_we, e.op != 3'b000);
                chk("ret_pc_inc", pc_inc, 1);
                chk("ret_code", code_sel, e.op);
                if (e.op != 3'b000) chk("ret_waddr", reg_waddr, e.rd);
                chk("ret_latency", cyc - e.stamp, e.lat);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] ins, input bit track, output int stamp);
        exp_t x;
        instr_in    = ins;
        instr_valid = 1'b1;
        stamp       = -1;
        for (int i = 0; i < 40 && stamp < 0; i++) begin
            if (instr_ready) begin
                stamp   = cyc;
                x.op    = ins[7:5];
                x.rd    = ins[4:3];
                x.stamp = cyc;
                x.lat   = ins[7:5] == 3'b110 ? 2 + MUL_LAT : ins[7:5] == 3'b000 ? 1 : 3;
                if (track) sb.push_back(x);
            end
            @(negedge clk);
        end
        if (stamp < 0) chk("accept_timeout", 0, 1);
        instr_valid = 1'b0;
        instr_in    = 8'($urandom);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int s1, s2;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_code", code_sel, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_waddr", reg_waddr, 0);
        chk("rst_pc_inc", pc_inc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(8'b001_10_000, 1, s1);
        chk("alu_decode_code", code_sel, 0);
        for (int i = 0; i < 3; i++) begin
            chk("alu_ready_low", instr_ready, 0);
            chk("alu_busy", busy, 1);
            if (i > 0) chk("alu_code", code_sel, 3'b001);
            @(negedge clk);
        end
        chk("alu_ready_back", instr_ready, 1);

        send(8'b110_01_000, 1, s1);
        chk("mul_decode_code", code_sel, 0);
        for (int i = 0; i < MUL_LAT; i++) begin
            @(negedge clk);
            chk("mul_exec_code", code_sel, 3'b110);
            chk("mul_exec_no_we", reg_we, 0);
        end
        repeat (2) @(negedge clk);

        send(8'b000_11_000, 1, s1);
        chk("nop_pc_inc", pc_inc, 1);
        chk("nop_we", reg_we, 0);
        @(negedge clk);
        chk("nop_idle", instr_ready, 1);

        send(8'b010_00_000, 1, s1);
        send(8'b101_11_000, 1, s2);
        chk("b2b_gap", s2 - s1, 4);
        repeat (4) @(negedge clk);

        send(8'b111_00_000, 0, s1);
        instr_valid = 1'b1;
        instr_in = 8'b001_01_000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1 || i == 19) begin
                chk("halt_halted", halted, 1);
                chk("halt_ready", instr_ready, 0);
                chk("halt_busy", busy, 0);
                chk("halt_code", code_sel, 0);
            end
        end
        instr_valid = 1'b0;
        pulse_reset();
        chk("halt_cleared", halted, 0);
        chk("halt_ready_back", instr_ready, 1);

        send(8'b110_10_000, 1, s1);
        @(negedge clk);
        chk("mid_exec_code", code_sel, 3'b110);
        #2 rst_n = 1'b0;
        #1;
        chk("async_code", code_sel, 0);
        chk("async_we", reg_we, 0);
        chk("async_pc_inc", pc_inc, 0);
        chk("async_ready", instr_ready, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_idle", instr_ready, 1);
        chk("post_rst_busy", busy, 0);

        send(8'b011_01_000, 1, s1);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
